audio_in_deserializer: RTL and testbench

Capture side of the DE1 audio codec path. Samples the ADC serial stream (left-justified, MSB first, left channel while LRCK high) using the one-cycle BCLK/LRCK edge strobes already produced in the clk domain. Assembles left/right words and pushes each complete stereo pair into two 128-deep synchronous FIFOs. Exposes show-ahead read ports and occupancy counts to the audio controller.

---
 rtl/audio_in_deserializer.sv | 163 ++++++++++++++++
 tb/tb_audio_in_deserializer.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/audio_in_deserializer.sv
// Codec ADC capture: assembles left-justified stereo words from BCLK/LRCK strobes
// and queues each complete pair into two show-ahead FIFOs.
module audio_in_deserializer_fifo #(
    parameter int DATA_WIDTH = 16,
    parameter int DEPTH      = 128,
    parameter int ADDR_WIDTH = 7
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  write,
    input  logic                  read,
    input  logic [DATA_WIDTH-1:0] write_data,
    output logic [DATA_WIDTH-1:0] head,
    output logic                  full,
    output logic [ADDR_WIDTH:0]   read_space
);
    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [ADDR_WIDTH-1:0] wr_ptr;
    logic [ADDR_WIDTH-1:0] rd_ptr;
    logic [ADDR_WIDTH:0]   used;
    logic [DATA_WIDTH-1:0] last_popped;
    logic                  empty;
    logic                  do_write;
    logic                  do_read;

    assign full     = (used == (ADDR_WIDTH+1)'(DEPTH));
    assign empty    = (used == '0);
    assign do_write = write && !full;
    assign do_read  = read && !empty;
    // An empty FIFO keeps presenting the most recently popped word.
    assign head     = empty ? last_popped : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_write) begin
            mem[wr_ptr] <= write_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            used        <= '0;
            last_popped <= '0;
            read_space  <= '0;
        end else begin
            if (do_write) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_read) begin
                rd_ptr      <= rd_ptr + 1'b1;
                last_popped <= mem[rd_ptr];
            end
            unique case ({do_write, do_read})
                2'b10:   used <= used + 1'b1;
                2'b01:   used <= used - 1'b1;
                default: used <= used;
            endcase
            read_space <= {full, used[ADDR_WIDTH-1:0]};
        end
    end
endmodule

module audio_in_deserializer #(
    parameter int AUDIO_DATA_WIDTH = 16,
    parameter int FIFO_DEPTH       = 128,
    parameter int FIFO_ADDR_WIDTH  = 7
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        bit_clk_rising_edge,
    input  logic                        bit_clk_falling_edge,
    input  logic                        left_right_clk_rising_edge,
    input  logic                        left_right_clk_falling_edge,
    input  logic                        serial_audio_in_data,
    input  logic                        read_left_audio_data_en,
    input  logic                        read_right_audio_data_en,
    output logic [AUDIO_DATA_WIDTH-1:0] left_channel_data,
    output logic [AUDIO_DATA_WIDTH-1:0] right_channel_data,
    output logic [FIFO_ADDR_WIDTH:0]    left_audio_fifo_read_space,
    output logic [FIFO_ADDR_WIDTH:0]    right_audio_fifo_read_space,
    output logic                        overflow
);
    localparam int CNT_W = $clog2(AUDIO_DATA_WIDTH + 1);
    localparam int IDX_W = $clog2(AUDIO_DATA_WIDTH);

    logic [AUDIO_DATA_WIDTH-1:0] shift_reg;
    logic [AUDIO_DATA_WIDTH-1:0] left_hold;
    logic [CNT_W-1:0]            bit_count;
    logic [IDX_W-1:0]            bit_index;
    logic                        aligned;
    logic                        left_valid;
    logic                        lr_edge;
    logic                        left_full;
    logic                        right_full;
    logic                        fifo_write;
    logic                        unused_falling;

    assign unused_falling = bit_clk_falling_edge;
    assign lr_edge        = left_right_clk_rising_edge || left_right_clk_falling_edge;
    assign bit_index      = IDX_W'(bit_count - 1'b1);
    // The right word is still in shift_reg during the LRCK-rise cycle that closes the frame.
    assign fifo_write     = left_right_clk_rising_edge && left_valid && !left_full && !right_full;

    always_ff @(posedge clk) begin
        if (reset) begin
            shift_reg  <= '0;
            left_hold  <= '0;
            bit_count  <= '0;
            aligned    <= 1'b0;
            left_valid <= 1'b0;
            overflow   <= 1'b0;
        end else begin
            if (lr_edge) begin
                bit_count <= CNT_W'(AUDIO_DATA_WIDTH);
                shift_reg <= '0;
            end else if (bit_clk_rising_edge && aligned && bit_count != '0) begin
                shift_reg[bit_index] <= serial_audio_in_data;
                bit_count            <= bit_count - 1'b1;
            end
            if (left_right_clk_rising_edge) begin
                aligned    <= 1'b1;
                left_valid <= 1'b0;
                if (left_valid && !fifo_write) begin
                    overflow <= 1'b1;
                end
            end else if (left_right_clk_falling_edge && aligned) begin
                left_hold  <= shift_reg;
                left_valid <= 1'b1;
            end
        end
    end

    audio_in_deserializer_fifo #(
        .DATA_WIDTH (AUDIO_DATA_WIDTH),
        .DEPTH      (FIFO_DEPTH),
        .ADDR_WIDTH (FIFO_ADDR_WIDTH)
    ) left_fifo (
        .clk        (clk),
        .reset      (reset),
        .write      (fifo_write),
        .read       (read_left_audio_data_en),
        .write_data (left_hold),
        .head       (left_channel_data),
        .full       (left_full),
        .read_space (left_audio_fifo_read_space)
    );

    audio_in_deserializer_fifo #(
        .DATA_WIDTH (AUDIO_DATA_WIDTH),
        .DEPTH      (FIFO_DEPTH),
        .ADDR_WIDTH (FIFO_ADDR_WIDTH)
    ) right_fifo (
        .clk        (clk),
        .reset      (reset),
        .write      (fifo_write),
        .read       (read_right_audio_data_en),
        .write_data (shift_reg),
        .head       (right_channel_data),
        .full       (right_full),
        .read_space (right_audio_fifo_read_space)
    );
endmodule

// File: tb/tb_audio_in_deserializer.sv
// Randomized bench for audio_in_deserializer against a frame-level queue model.
module tb_audio_in_deserializer;
    logic        clk = 1'b0;
    logic        reset;
    logic        bit_clk_rising_edge, bit_clk_falling_edge;
    logic        left_right_clk_rising_edge, left_right_clk_falling_edge;
    logic        serial_audio_in_data;
    logic        read_left_audio_data_en, read_right_audio_data_en;
    logic [15:0] left_channel_data, right_channel_data;
    logic [7:0]  left_audio_fifo_read_space, right_audio_fifo_read_space;
    logic        overflow;

    always #5 clk = ~clk;

    audio_in_deserializer #(
        .AUDIO_DATA_WIDTH (16),
        .FIFO_DEPTH       (128),
        .FIFO_ADDR_WIDTH  (7)
    ) dut (
        .clk                         (clk),
        .reset                       (reset),
        .bit_clk_rising_edge         (bit_clk_rising_edge),
        .bit_clk_falling_edge        (bit_clk_falling_edge),
        .left_right_clk_rising_edge  (left_right_clk_rising_edge),
        .left_right_clk_falling_edge (left_right_clk_falling_edge),
        .serial_audio_in_data        (serial_audio_in_data),
        .read_left_audio_data_en     (read_left_audio_data_en),
        .read_right_audio_data_en    (read_right_audio_data_en),
        .left_channel_data           (left_channel_data),
        .right_channel_data          (right_channel_data),
        .left_audio_fifo_read_space  (left_audio_fifo_read_space),
        .right_audio_fifo_read_space (right_audio_fifo_read_space),
        .overflow                    (overflow)
    );

    int n_checks = 0;
    int n_pass   = 0;

    // Frame-level reference state
    logic [15:0] ql[$];
    logic [15:0] qr[$];
    logic [15:0] last_l, last_r, left_word, cur_word;
    logic [15:0] push_lw, push_rw;
    bit          aligned, pending, push_req, ovf, force_pop;
    int          prev_l, prev_r, pop_pct;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    endtask

    task automatic clear_inputs();
        bit_clk_rising_edge         = 1'b0;
        bit_clk_falling_edge        = 1'b0;
        left_right_clk_rising_edge  = 1'b0;
        left_right_clk_falling_edge = 1'b0;
        serial_audio_in_data        = 1'b0;
        read_left_audio_data_en     = 1'b0;
        read_right_audio_data_en    = 1'b0;
    endtask

    task automatic do_reset();
        clear_inputs();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        ql.delete(); qr.delete();
        last_l = '0; last_r = '0; left_word = '0; cur_word = '0;
        aligned = 0; pending = 0; push_req = 0; ovf = 0;
        prev_l = 0; prev_r = 0;
        chk("rst_space_l", left_audio_fifo_read_space, 0);
        chk("rst_space_r", right_audio_fifo_read_space, 0);
        chk("rst_data_l", left_channel_data, 0);
        chk("rst_data_r", right_channel_data, 0);
        chk("rst_overflow", overflow, 0);
    endtask

    // One clk cycle: drive at negedge, update model at posedge, check at next negedge.
    task automatic cyc(input logic lrr, input logic lrf, input logic br, input logic bf, input logic d);
        logic pl, pr;
        bit   room;
        pl = force_pop || ($urandom_range(0, 99) < pop_pct);
        pr = force_pop || ($urandom_range(0, 99) < pop_pct);
        left_right_clk_rising_edge  = lrr;
        left_right_clk_falling_edge = lrf;
        bit_clk_rising_edge         = br;
        bit_clk_falling_edge        = bf;
        serial_audio_in_data        = d;
        read_left_audio_data_en     = pl;
        read_right_audio_data_en    = pr;
        @(posedge clk);
        prev_l = ql.size();
        prev_r = qr.size();
        room = (ql.size() < 128) && (qr.size() < 128);
        if (pl && ql.size() > 0) last_l = ql.pop_front();
        if (pr && qr.size() > 0) last_r = qr.pop_front();
        if (push_req) begin
            if (room) begin
                ql.push_back(push_lw);
                qr.push_back(push_rw);
            end else begin
                ovf = 1;
            end
            push_req = 0;
        end
        @(negedge clk);
        clear_inputs();
        chk("space_l", left_audio_fifo_read_space, prev_l);
        chk("space_r", right_audio_fifo_read_space, prev_r);
        chk("head_l", left_channel_data, ql.size() > 0 ? ql[0] : last_l);
        chk("head_r", right_channel_data, qr.size() > 0 ? qr[0] : last_r);
        chk("overflow", overflow, ovf);
    endtask

    task automatic idle(input int n);
        repeat (n) cyc(0, 0, 0, 0, 0);
    endtask

    // One LRCK half: optional LRCK edge, then nslot BCLK rises each div clks apart.
    task automatic half(input bit is_left, input bit with_edge, input logic [15:0] w,
                        input int nslot, input int div, input bit coin);
        logic [15:0] cap;
        if (with_edge) begin
            if (is_left) begin
                if (aligned && pending) begin
                    push_req = 1; push_lw = left_word; push_rw = cur_word;
                end
                pending = 0;
                aligned = 1;
            end else if (aligned) begin
                left_word = cur_word;
                pending   = 1;
            end
            cyc(is_left, !is_left, coin, 0, coin);
        end
        cap = '0;
        for (int k = 0; k < nslot; k++) begin
            logic b;
            b = (k < 16) ? w[15-k] : 1'($urandom);
            if (k < 16) cap[15-k] = b;
            for (int j = 1; j < div; j++) cyc(0, 0, 0, (j == 1), 0);
            cyc(0, 0, 1, 0, b);
        end
        cur_word = cap;
    endtask

    task automatic frame(input logic [15:0] lw, input logic [15:0] rw,
                         input int nslot, input int div, input bit coin);
        half(1, 1, lw, nslot, div, coin);
        half(0, 1, rw, nslot, div, coin);
    endtask

    task automatic flush(input bit coin);
        half(1, 1, 16'h0, 0, 2, coin);
        idle(2);
    endtask

    task automatic drain(input int n);
        force_pop = 1;
        idle(n);
        force_pop = 0;
    endtask

    initial begin
        logic [15:0] wl, wr;
        force_pop = 0;
        pop_pct   = 0;
        do_reset();

        // Start mid right half, then one full 32-bit-slot frame at BCLK = clk/16
        half(0, 0, 16'hFFFF, 20, 16, 0);
        chk("pre_align_space", left_audio_fifo_read_space, 0);
        frame(16'hA5C3, 16'h3C5A, 32, 16, 0);
        chk("no_partial_space", left_audio_fifo_read_space, 0);
        flush(0);
        chk("t1_space_l", left_audio_fifo_read_space, 1);
        chk("t1_space_r", right_audio_fifo_read_space, 1);
        chk("t1_head_l", left_channel_data, 16'hA5C3);
        chk("t1_head_r", right_channel_data, 16'h3C5A);

        // Pops on an empty FIFO, then a fresh frame must read back intact
        drain(4);
        chk("empty_space", left_audio_fifo_read_space, 0);
        wl = 16'($urandom); wr = 16'($urandom);
        frame(wl, wr, 16, 2, 0);
        flush(0);
        chk("after_empty_l", left_channel_data, wl);
        chk("after_empty_r", right_channel_data, wr);

        // BCLK rise coincident with every LRCK edge, data high
        drain(3);
        frame(16'h8001, 16'h8001, 16, 4, 1);
        flush(1);
        chk("coin_l", left_channel_data, 16'h8001);
        chk("coin_r", right_channel_data, 16'h8001);

        // Short half-frame of 12 bits, all ones
        drain(3);
        frame(16'hFFFF, 16'hFFFF, 12, 3, 0);
        flush(0);
        chk("short_l", left_channel_data, 16'hFFF0);
        chk("short_r", right_channel_data, 16'hFFF0);

        // 129 complete frames without pops: 128 kept, last dropped
        do_reset();
        for (int i = 0; i < 130; i++) frame(16'($urandom), 16'($urandom), 16, 2, 0);
        idle(2);
        chk("full_space_l", left_audio_fifo_read_space, 8'h80);
        chk("full_space_r", right_audio_fifo_read_space, 8'h80);
        chk("full_overflow", overflow, 1);
        drain(132);
        chk("drained_space", left_audio_fifo_read_space, 0);

        // Random traffic with random pops and a mid-frame reset
        do_reset();
        pop_pct = 15;
        for (int i = 0; i < 50; i++) begin
            if (i == 25) begin
                half(1, 1, 16'($urandom), 8, 2, 0);
                do_reset();
            end
            frame(16'($urandom), 16'($urandom), $urandom_range(10, 22),
                  $urandom_range(2, 3), 1'($urandom));
        end
        flush(0);
        pop_pct = 0;
        drain(10);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end
endmodule
